// File: rtl/mfp_adc_sample_fifo.sv
// -----------------------------------------------------------------------------
// mfp_adc_sample_fifo
//
// Purpose:
//   This is a tagged sample FIFO that sits directly behind the MAX10 ADC
//   sequencer response stream. Every response beat ({EOP, SOP, channel, data})
//   is captured while the FIFO is enabled. The CPU drains it through a small
//   register port. Reading FIFOD while the FIFO is non-empty pops the entry
//   that is presented in that same cycle. A registered level interrupt fires
//   on a fill threshold or on overflow.
//
// Configuration macro:
//   ADC_FIFO_DROP_OLDEST_EN
//     undefined : on overflow the newest beat is dropped.
//     defined   : on overflow the newest beat overwrites the oldest entry.
//   The ovf flag is set in both cases.
//
// Ports:
//   CLK, RESET          system clock and synchronous active-high reset
//   ADC_R_Valid         response beat valid
//   ADC_R_Channel[4:0]  beat channel
//   ADC_R_Data[11:0]    conversion result
//   ADC_R_SOP/EOP       first/last beat of a sequence
//   read_addr[1:0]      register select for reads
//   read_enable         read strobe (pops when it addresses FIFOD)
//   read_data[31:0]     combinational read mux
//   write_addr[1:0]     register select for writes
//   write_data[31:0]    write data
//   write_enable        write strobe
//   FIFO_Interrupt      registered level interrupt
//
// Register map:
//   0 FIFOD  {valid[31], eop[30], sop[29], channel[20:16], data[11:0]}
//   1 FIFOS  count[DEPTH_LOG2:0], empty[24], full[25], ovf[26] (W1C), thr[27]
//   2 FIFOC  en[0], ie[1], flush[2] (self-clearing), threshold[DEPTH_LOG2+8:8]
//   3        reads 0, writes ignored
// -----------------------------------------------------------------------------
module mfp_adc_sample_fifo #(
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        ADC_R_Valid,
   input  logic [4:0]  ADC_R_Channel,
   input  logic [11:0] ADC_R_Data,
   input  logic        ADC_R_SOP,
   input  logic        ADC_R_EOP,
   input  logic [1:0]  read_addr,
   input  logic        read_enable,
   output logic [31:0] read_data,
   input  logic [1:0]  write_addr,
   input  logic [31:0] write_data,
   input  logic        write_enable,
   output logic        FIFO_Interrupt
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned PW    = DEPTH_LOG2 + 1;
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [PW-1:0] PTR_ZERO = PW'(0);

   // Storage: {eop, sop, channel[4:0], data[11:0]}
   logic [18:0]   mem_q [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] thr_q, thr_d;
   logic          en_q, en_d;
   logic          ie_q, ie_d;
   logic          ovf_q, ovf_d;
   logic          irq_q, irq_d;

   logic [PW-1:0] count_s;
   logic          empty_s;
   logic          full_s;
   logic          thr_s;
   logic          push_req_s;
   logic          push_s;
   logic          pop_s;
   logic          rd_adv_s;
   logic          ovf_set_s;
   logic          flush_s;
   logic          wr_fifos_s;
   logic          wr_fifoc_s;
   logic [18:0]   head_s;
   logic [31:0]   fifod_s;
   logic [31:0]   fifos_s;
   logic [31:0]   fifoc_s;
   logic          unused_wdata_s;

   // Only a few write_data bits are meaningful.
   assign unused_wdata_s = ^write_data;

   // Pointer-derived status. The wrap bit tells a full FIFO apart from an
   // empty one.
   assign empty_s = (wr_ptr_q == rd_ptr_q);
   assign full_s  = (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]) &&
                    (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]);
   assign count_s = wr_ptr_q - rd_ptr_q;
   assign thr_s   = (thr_q != PTR_ZERO) && (count_s >= thr_q);

   assign wr_fifos_s = write_enable && (write_addr == 2'd1);
   assign wr_fifoc_s = write_enable && (write_addr == 2'd2);
   assign flush_s    = wr_fifoc_s && write_data[2];

   assign push_req_s = ADC_R_Valid && en_q;
   assign pop_s      = read_enable && (read_addr == 2'd0) && !empty_s;
   // An overflow only happens when no pop frees a slot in the same cycle.
   assign ovf_set_s  = push_req_s && full_s && !pop_s;

`ifdef ADC_FIFO_DROP_OLDEST_EN
   // Always accept the beat. When the FIFO is full, the read pointer is pushed
   // forward so the oldest entry is overwritten. A concurrent pop collapses
   // into that same single advance.
   assign push_s   = push_req_s;
   assign rd_adv_s = pop_s || (push_req_s && full_s);
`else
   // When the FIFO is full and nothing pops, drop the new beat and keep the
   // existing contents.
   assign push_s   = push_req_s && (!full_s || pop_s);
   assign rd_adv_s = pop_s;
`endif

   // Next-state logic for the pointers, control fields, the ovf flag and the interrupt.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      en_d     = en_q;
      ie_d     = ie_q;
      thr_d    = thr_q;
      ovf_d    = ovf_q;
      irq_d    = 1'b0;

      if (flush_s) begin
         wr_ptr_d = PTR_ZERO;
         rd_ptr_d = PTR_ZERO;
      end else begin
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (rd_adv_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
      end

      // Priority: flush clears ovf, then a new overflow sets it, then a
      // write-1 clears it.
      if (flush_s) begin
         ovf_d = 1'b0;
      end else if (ovf_set_s) begin
         ovf_d = 1'b1;
      end else if (wr_fifos_s && write_data[26]) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end

      if (wr_fifoc_s) begin
         en_d  = write_data[0];
         ie_d  = write_data[1];
         thr_d = write_data[DEPTH_LOG2+8:8];
      end else begin
         en_d  = en_q;
         ie_d  = ie_q;
         thr_d = thr_q;
      end

      irq_d = ie_q && (thr_s || ovf_q);
   end

   // State registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         wr_ptr_q <= PTR_ZERO;
         rd_ptr_q <= PTR_ZERO;
         en_q     <= 1'b0;
         ie_q     <= 1'b0;
         thr_q    <= PTR_ZERO;
         ovf_q    <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         en_q     <= en_d;
         ie_q     <= ie_d;
         thr_q    <= thr_d;
         ovf_q    <= ovf_d;
         irq_q    <= irq_d;
      end
   end

   // Sample storage. The contents need no reset because the pointers define
   // which entries are valid.
   always_ff @(posedge CLK) begin
      if (push_s && !flush_s && !RESET) begin
         mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= {ADC_R_EOP, ADC_R_SOP, ADC_R_Channel, ADC_R_Data};
      end
   end

   assign head_s = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

   // Register images for the read mux.
   always_comb begin
      if (empty_s) begin
         fifod_s = 32'd0;
      end else begin
         fifod_s = {1'b1, head_s[18], head_s[17], 8'd0, head_s[16:12], 4'd0, head_s[11:0]};
      end

      fifos_s               = 32'd0;
      fifos_s[PW-1:0]       = count_s;
      fifos_s[24]           = empty_s;
      fifos_s[25]           = full_s;
      fifos_s[26]           = ovf_q;
      fifos_s[27]           = thr_s;

      fifoc_s                   = 32'd0;
      fifoc_s[0]                = en_q;
      fifoc_s[1]                = ie_q;
      fifoc_s[DEPTH_LOG2+8:8]   = thr_q;
   end

   // Combinational read data select.
   always_comb begin
      read_data = 32'd0;
      case (read_addr)
         2'd0:    read_data = fifod_s;
         2'd1:    read_data = fifos_s;
         2'd2:    read_data = fifoc_s;
         default: read_data = 32'd0;
      endcase
   end

   assign FIFO_Interrupt = irq_q;

endmodule
